// File: rtl/tca9539_port_if.sv
// Pin-side bundle of the TCA9539 expander: register-file inputs, pad levels,
// pin drive, input-port values and the interrupt line.
interface tca9539_port_if;
  logic [15:0] pin_in;
  logic [15:0] pin_out;
  logic [15:0] pin_oe;
  logic [7:0]  output_port_0;
  logic [7:0]  output_port_1;
  logic [7:0]  polarity_inversion_port_0;
  logic [7:0]  polarity_inversion_port_1;
  logic [7:0]  configuration_port_0;
  logic [7:0]  configuration_port_1;
  logic        rd_input_0;
  logic        rd_input_1;
  logic [7:0]  input_port_0;
  logic [7:0]  input_port_1;
  logic        int_n;

  // Register file / pad side: supplies registers, strobes and pad levels.
  modport master (
    output pin_in,
    output output_port_0, output_port_1,
    output polarity_inversion_port_0, polarity_inversion_port_1,
    output configuration_port_0, configuration_port_1,
    output rd_input_0, rd_input_1,
    input  pin_out, pin_oe,
    input  input_port_0, input_port_1,
    input  int_n
  );

  // Port logic side.
  modport slave (
    input  pin_in,
    input  output_port_0, output_port_1,
    input  polarity_inversion_port_0, polarity_inversion_port_1,
    input  configuration_port_0, configuration_port_1,
    input  rd_input_0, rd_input_1,
    output pin_out, pin_oe,
    output input_port_0, input_port_1,
    output int_n
  );
endinterface

// File: rtl/tca9539_port_logic.sv
// TCA9539 pin-side stage: drives the GPIO pins from the output/config
// registers, synchronises and filters the pad levels into the input-port
// registers, and raises the active-low interrupt with clear-on-read.
module tca9539_port_logic #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input logic           clk,
  input logic           rst,
  tca9539_port_if.slave bus
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [15:0]      sync_q [SYNC_STAGES];
  logic [15:0]      s_vec;
  logic [15:0]      s_prev_q;
  logic             stable_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      pin_filt_q, pin_filt_d;
  logic [15:0]      snap_q, snap_d;
  logic [15:0]      prev_cfg_q;
  logic [15:0]      cfg_s;
  logic [15:0]      rise_s;
  logic [15:0]      rd_mask_s;
  logic [15:0]      pend_s;
  logic [7:0]       input_port_0_q, input_port_1_q;
  logic [15:0]      pin_out_q, pin_oe_q;
  logic             int_n_q;

  assign s_vec     = sync_q[SYNC_STAGES-1];
  assign cfg_s     = {bus.configuration_port_1, bus.configuration_port_0};
  assign rise_s    = cfg_s & ~prev_cfg_q;
  assign rd_mask_s = {{8{bus.rd_input_1}}, {8{bus.rd_input_0}}};

  // Pad synchroniser chain; stage 0 samples the asynchronous pad levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= 16'hFFFF;
      end
    end else begin
      sync_q[0] <= bus.pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Whole-vector filter: a new vector is accepted only after it has held
  // steady across FILTER_LEN consecutive sample-to-sample comparisons.
  always_comb begin
    stable_s   = (s_vec == s_prev_q);
    cnt_d      = '0;
    pin_filt_d = pin_filt_q;
    if (stable_s) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d      = cnt_q;
        pin_filt_d = s_vec;
      end else begin
        cnt_d      = cnt_q + CNT_ONE;
        pin_filt_d = pin_filt_q;
      end
    end else begin
      cnt_d      = '0;
      pin_filt_d = pin_filt_q;
    end
  end

  // Snapshot capture: a 0->1 config change re-baselines the bit (wins over a
  // read strobe); a read strobe re-baselines its whole byte. Both capture the
  // pre-update filtered level. The interrupt compares against this next
  // snapshot so a capture never produces a one-cycle spurious assertion.
  always_comb begin
    snap_d = snap_q;
    for (int i = 0; i < 16; i++) begin
      if (rise_s[i]) begin
        snap_d[i] = pin_filt_q[i];
      end else if (rd_mask_s[i]) begin
        snap_d[i] = pin_filt_q[i];
      end else begin
        snap_d[i] = snap_q[i];
      end
    end
    pend_s = cfg_s & (pin_filt_q ^ snap_d);
  end

  // Filter, snapshot, interrupt, input-port and pin-drive registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev_q       <= 16'hFFFF;
      cnt_q          <= '0;
      pin_filt_q     <= 16'hFFFF;
      snap_q         <= 16'hFFFF;
      prev_cfg_q     <= 16'hFFFF;
      input_port_0_q <= 8'hFF;
      input_port_1_q <= 8'hFF;
      pin_out_q      <= 16'hFFFF;
      pin_oe_q       <= 16'h0000;
      int_n_q        <= 1'b1;
    end else begin
      s_prev_q       <= s_vec;
      cnt_q          <= cnt_d;
      pin_filt_q     <= pin_filt_d;
      snap_q         <= snap_d;
      prev_cfg_q     <= cfg_s;
      input_port_0_q <= pin_filt_q[7:0]  ^ bus.polarity_inversion_port_0;
      input_port_1_q <= pin_filt_q[15:8] ^ bus.polarity_inversion_port_1;
      pin_out_q      <= {bus.output_port_1, bus.output_port_0};
      pin_oe_q       <= ~cfg_s;
      int_n_q        <= ~(|pend_s);
    end
  end

  assign bus.input_port_0 = input_port_0_q;
  assign bus.input_port_1 = input_port_1_q;
  assign bus.pin_out      = pin_out_q;
  assign bus.pin_oe       = pin_oe_q;
  assign bus.int_n        = int_n_q;

endmodule

// File: tb/tb_tca9539_port_logic.sv
// Self-checking bench for tca9539_port_logic: a behavioural model checked
// every cycle plus directed vectors with literal expectations.
module tb_tca9539_port_logic;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tca9539_port_if bus ();

  tca9539_port_logic #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pad levels reach the filter SYNC_STAGES edges late (delay line); the
  // filtered vector changes once a value has been seen on FILTER_LEN+1
  // consecutive edges (the saved previous sample included).
  logic [15:0] m_dly[$];
  logic [15:0] m_run_val;
  int          m_run_len;
  logic [15:0] m_filt, m_snap, m_prev_cfg, m_pout, m_poe;
  logic [7:0]  m_in0, m_in1;
  logic        m_int_n;
  bit          m_valid = 1'b0;

  task automatic model_step();
    logic [15:0] s, cfg, cap, snap_n;
    if (rst) begin
      m_dly.delete();
      for (int i = 0; i < SYNC_STAGES; i++) m_dly.push_back(16'hFFFF);
      m_run_val  = 16'hFFFF;
      m_run_len  = 1;
      m_filt     = 16'hFFFF;
      m_snap     = 16'hFFFF;
      m_prev_cfg = 16'hFFFF;
      m_in0      = 8'hFF;
      m_in1      = 8'hFF;
      m_pout     = 16'hFFFF;
      m_poe      = 16'h0000;
      m_int_n    = 1'b1;
      m_valid    = 1'b1;
    end else if (m_valid) begin
      s = m_dly.pop_front();
      m_dly.push_back(bus.pin_in);
      cfg    = {bus.configuration_port_1, bus.configuration_port_0};
      cap    = (cfg & ~m_prev_cfg) | {{8{bus.rd_input_1}}, {8{bus.rd_input_0}}};
      snap_n = (m_snap & ~cap) | (m_filt & cap);
      m_int_n = ((cfg & (m_filt ^ snap_n)) == 16'h0000);
      m_in0   = m_filt[7:0]  ^ bus.polarity_inversion_port_0;
      m_in1   = m_filt[15:8] ^ bus.polarity_inversion_port_1;
      if (s == m_run_val) begin
        if (m_run_len < 1000) m_run_len++;
      end else begin
        m_run_val = s;
        m_run_len = 1;
      end
      if (m_run_len > FILTER_LEN) m_filt = m_run_val;
      m_snap     = snap_n;
      m_prev_cfg = cfg;
      m_pout     = {bus.output_port_1, bus.output_port_0};
      m_poe      = ~cfg;
    end
  endtask

  // Model advances on every active edge.
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare every DUT output with the model on each falling edge.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("mdl_pin_out", bus.pin_out, m_pout);
      chk("mdl_pin_oe", bus.pin_oe, m_poe);
      chk("mdl_in0", {8'h00, bus.input_port_0}, {8'h00, m_in0});
      chk("mdl_in1", {8'h00, bus.input_port_1}, {8'h00, m_in1});
      chk("mdl_int_n", {15'h0, bus.int_n}, {15'h0, m_int_n});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rd(input bit p0, input bit p1);
    bus.rd_input_0 = p0;
    bus.rd_input_1 = p1;
    cyc(1);
    bus.rd_input_0 = 1'b0;
    bus.rd_input_1 = 1'b0;
  endtask

  initial begin
    rst                           = 1'b1;
    bus.pin_in                    = 16'hFFFF;
    bus.output_port_0             = 8'hFF;
    bus.output_port_1             = 8'hFF;
    bus.polarity_inversion_port_0 = 8'h00;
    bus.polarity_inversion_port_1 = 8'h00;
    bus.configuration_port_0      = 8'hFF;
    bus.configuration_port_1      = 8'hFF;
    bus.rd_input_0                = 1'b0;
    bus.rd_input_1                = 1'b0;

    // Reset state
    cyc(2);
    chk("rst_in0", {8'h00, bus.input_port_0}, 16'h00FF);
    chk("rst_in1", {8'h00, bus.input_port_1}, 16'h00FF);
    chk("rst_int_n", {15'h0, bus.int_n}, 16'h0001);
    chk("rst_pin_oe", bus.pin_oe, 16'h0000);
    chk("rst_pin_out", bus.pin_out, 16'hFFFF);
    rst = 1'b0;
    cyc(8);

    // Configuration and drive; output pins never interrupt
    bus.configuration_port_0 = 8'h0F;
    bus.output_port_0        = 8'hA5;
    cyc(1);
    chk("drv_pin_oe", bus.pin_oe, 16'h00F0);
    chk("drv_pin_out", bus.pin_out, 16'hFFA5);
    bus.pin_in = 16'hFFEF;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("out_pin_no_int", {15'h0, bus.int_n}, 16'h0001);
    end
    bus.pin_in = 16'hFFFF;
    cyc(10);

    // Input change latency with polarity inversion on bit 8
    bus.polarity_inversion_port_1 = 8'h01;
    cyc(2);
    chk("pol_in1_idle", {8'h00, bus.input_port_1}, 16'h00FE);
    bus.pin_in = 16'hFEFF;
    cyc(6);
    chk("lat_int_early", {15'h0, bus.int_n}, 16'h0001);
    chk("lat_in1_early", {8'h00, bus.input_port_1}, 16'h00FE);
    cyc(1);
    chk("lat_int_n", {15'h0, bus.int_n}, 16'h0000);
    chk("lat_in1", {8'h00, bus.input_port_1}, 16'h00FF);
    pulse_rd(1'b0, 1'b1);
    chk("rd1_clear", {15'h0, bus.int_n}, 16'h0001);
    bus.pin_in = 16'hFFFF;
    cyc(8);
    chk("rd1_return_int", {15'h0, bus.int_n}, 16'h0000);
    pulse_rd(1'b0, 1'b1);
    chk("rd1_clear2", {15'h0, bus.int_n}, 16'h0001);

    // Glitch rejection: 2-clock pulse rejected
    bus.pin_in = 16'hFFF7;
    cyc(2);
    bus.pin_in = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("glitch_in0", {8'h00, bus.input_port_0}, 16'h00FF);
      chk("glitch_int_n", {15'h0, bus.int_n}, 16'h0001);
    end
    // A pulse seen on FILTER_LEN+1 sampling edges is accepted
    bus.pin_in = 16'hFFF7;
    cyc(4);
    bus.pin_in = 16'hFFFF;
    cyc(3);
    chk("pulse_in0", {8'h00, bus.input_port_0}, 16'h00F7);
    chk("pulse_int_n", {15'h0, bus.int_n}, 16'h0000);
    cyc(10);
    chk("pulse_selfclr", {15'h0, bus.int_n}, 16'h0001);

    // Self-clear of bit 0 without a read
    bus.pin_in = 16'hFFFE;
    cyc(8);
    chk("sc_int_set", {15'h0, bus.int_n}, 16'h0000);
    bus.pin_in = 16'hFFFF;
    cyc(6);
    chk("sc_int_early", {15'h0, bus.int_n}, 16'h0000);
    cyc(1);
    chk("sc_int_clr", {15'h0, bus.int_n}, 16'h0001);

    // Read strobe in the same cycle pin_filt[1] falls
    bus.pin_in = 16'hFFFD;
    cyc(5);
    pulse_rd(1'b1, 1'b0);
    chk("sim_int_hold", {15'h0, bus.int_n}, 16'h0001);
    cyc(1);
    chk("sim_int_set", {15'h0, bus.int_n}, 16'h0000);
    pulse_rd(1'b1, 1'b0);
    chk("sim_clear", {15'h0, bus.int_n}, 16'h0001);
    bus.pin_in = 16'hFFFF;
    cyc(8);
    pulse_rd(1'b1, 1'b0);
    chk("sim_clear2", {15'h0, bus.int_n}, 16'h0001);

    // Config 0->1 on bit 7 while its filtered level is low
    bus.pin_in = 16'hFF7F;
    cyc(8);
    chk("cfg_pre_int", {15'h0, bus.int_n}, 16'h0001);
    chk("cfg_pre_in0", {8'h00, bus.input_port_0}, 16'h007F);
    bus.configuration_port_0 = 8'h8F;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("cfg_rise_no_int", {15'h0, bus.int_n}, 16'h0001);
    end

    // Mid-operation reset, then both read strobes together
    bus.pin_in = 16'hFB7F;
    cyc(8);
    chk("mr_int_set", {15'h0, bus.int_n}, 16'h0000);
    rst = 1'b1;
    cyc(1);
    chk("mr_int_rst", {15'h0, bus.int_n}, 16'h0001);
    chk("mr_in0_rst", {8'h00, bus.input_port_0}, 16'h00FF);
    rst = 1'b0;
    cyc(8);
    chk("mr_int_again", {15'h0, bus.int_n}, 16'h0000);
    pulse_rd(1'b1, 1'b1);
    chk("both_rd_clear", {15'h0, bus.int_n}, 16'h0001);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
